spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_if.sv | 28 ++
 rtl/spi_tick.sv | 24 ++
 rtl/spi_master.sv | 115 +++++++++++
 tb/tb_spi_master.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI master types: FSM state encoding and default frame parameters.
package spi_pkg;

  localparam int SPI_CLK_DIV_DEFAULT = 4;
  localparam int SPI_NBITS_DEFAULT   = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SCK_HIGH = 3'd2,
    ST_SCK_LOW  = 3'd3,
    ST_GAP      = 3'd4
  } spi_state_t;

endpackage

// File: rtl/spi_if.sv
// Frame request/response and serial pin bundle between a host and the SPI master.
interface spi_if
  import spi_pkg::*;
#(
  parameter int NBITS = SPI_NBITS_DEFAULT
);

  logic             start;
  logic [NBITS-1:0] tx_data;
  logic [NBITS-1:0] rx_data;
  logic             busy;
  logic             done;
  logic             sck;
  logic             ssel;
  logic             mosi;
  logic             miso;

  modport master (
    input  start, tx_data, miso,
    output rx_data, busy, done, sck, ssel, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  rx_data, busy, done, sck, ssel, mosi
  );

endinterface

// File: rtl/spi_tick.sv
// Half-period down-counter; strobe marks the last cycle of the current phase.
module spi_tick (
  input  logic       clk,
  input  logic       rst,
  input  logic       reload,
  input  logic [7:0] load_val,
  output logic       strobe
);

  logic [7:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= 8'd0;
    end else if (reload) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != 8'd0) begin
      cnt_reg <= cnt_reg - 8'd1;
    end
  end

  assign strobe = (cnt_reg == 8'd0);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one full-duplex NBITS frame per accepted start, MSB first.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT,
  parameter int NBITS   = SPI_NBITS_DEFAULT
) (
  input logic   clk,
  input logic   rst,
  spi_if.master bus
);

  localparam int             BCW       = $clog2(NBITS + 1);
  localparam logic [7:0]     HALF_LOAD = 8'(CLK_DIV - 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(NBITS);

  spi_state_t       state_reg;
  logic [NBITS-2:0] tx_sh_reg;
  logic [NBITS-1:0] rx_sh_reg;
  logic [NBITS-1:0] rx_data_reg;
  logic [BCW-1:0]   bit_cnt_reg;
  logic             sck_reg;
  logic             ssel_reg;
  logic             mosi_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             phase_end;
  logic             reload;

  // Every phase lasts CLK_DIV cycles, so the counter restarts on acceptance and at each phase end.
  assign reload = (state_reg == ST_IDLE) ? bus.start : phase_end;

  spi_tick u_tick (
    .clk      (clk),
    .rst      (rst),
    .reload   (reload),
    .load_val (HALF_LOAD),
    .strobe   (phase_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      sck_reg     <= 1'b0;
      ssel_reg    <= 1'b1;
      mosi_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      rx_data_reg <= '0;
      tx_sh_reg   <= '0;
      rx_sh_reg   <= '0;
      bit_cnt_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            state_reg   <= ST_SETUP;
            mosi_reg    <= bus.tx_data[NBITS-1];
            tx_sh_reg   <= bus.tx_data[NBITS-2:0];
            ssel_reg    <= 1'b0;
            busy_reg    <= 1'b1;
            bit_cnt_reg <= '0;
          end
        end
        ST_SETUP: begin
          if (phase_end) begin
            state_reg <= ST_SCK_HIGH;
            sck_reg   <= 1'b1;
          end
        end
        ST_SCK_HIGH: begin
          // Falling edge: sample miso and present the next bit in the same cycle.
          if (phase_end) begin
            state_reg   <= ST_SCK_LOW;
            sck_reg     <= 1'b0;
            rx_sh_reg   <= {rx_sh_reg[NBITS-2:0], bus.miso};
            mosi_reg    <= tx_sh_reg[NBITS-2];
            tx_sh_reg   <= tx_sh_reg << 1;
            bit_cnt_reg <= bit_cnt_reg + BCW'(1);
          end
        end
        ST_SCK_LOW: begin
          if (phase_end) begin
            if (bit_cnt_reg == LAST_BIT) begin
              state_reg <= ST_GAP;
              ssel_reg  <= 1'b1;
              mosi_reg  <= 1'b0;
            end else begin
              state_reg <= ST_SCK_HIGH;
              sck_reg   <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (phase_end) begin
            state_reg   <= ST_IDLE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            rx_data_reg <= rx_sh_reg;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.rx_data = rx_data_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.sck     = sck_reg;
  assign bus.ssel    = ssel_reg;
  assign bus.mosi    = mosi_reg;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a D=4/32-bit and a D=2/8-bit instance, each checked every cycle against a frame-timing model.
`timescale 1ns/1ps
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic        rst_v      [2];
  logic        start_v    [2];
  logic [31:0] tx_v       [2];
  logic        loop_v     [2];
  logic [31:0] slave_word [2];
  int          start_cyc  [2];
  int          done_count [2];
  int          done_rel   [2];
  int          rise_cnt   [2];
  logic [31:0] mosi_seq   [2];
  int          last_gap   [2];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endfunction

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g
    localparam int D = (gi == 0) ? 4 : 2;
    localparam int N = (gi == 0) ? 32 : 8;

    spi_if #(.NBITS(N)) bus ();

    logic [N-1:0] slave_sh  = '0;
    logic         prev_sck  = 1'b0;
    logic         prev_ssel = 1'b1;
    logic         obs_sck   = 1'b0;
    bit           armed     = 1'b0;
    bit           active    = 1'b0;
    int           t0        = 0;
    int           ssel_run  = 0;
    logic [N-1:0] tx_cap    = '0;
    logic [N-1:0] rx_next   = '0;
    logic [N-1:0] rx_model  = '0;

    assign bus.start   = start_v[gi];
    assign bus.tx_data = tx_v[gi][N-1:0];
    assign bus.miso    = loop_v[gi] ? bus.mosi : slave_sh[N-1];

    spi_master #(.CLK_DIV(D), .NBITS(N)) dut (
      .clk (clk),
      .rst (rst_v[gi]),
      .bus (bus)
    );

    // Slave: presents its MSB when selected, shifts after every falling sck.
    always @(negedge clk) begin
      if (prev_ssel === 1'b1 && bus.ssel === 1'b0)
        slave_sh <= slave_word[gi][N-1:0];
      else if (prev_sck === 1'b1 && bus.sck === 1'b0)
        slave_sh <= slave_sh << 1;
      prev_sck  <= bus.sck;
      prev_ssel <= bus.ssel;
    end

    // Model: position t within the frame decides every pin value.
    always @(negedge clk) begin
      int t, u, k;
      logic e_sck, e_ssel, e_mosi, e_busy, e_done, mosi_known;
      e_sck = 1'b0; e_ssel = 1'b1; e_mosi = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      mosi_known = 1'b1;
      t = 0; u = 0; k = 0;
      if (active) begin
        t = cyc - t0;
        if (t <= D) begin
          e_ssel = 1'b0; e_busy = 1'b1; e_mosi = tx_cap[N-1];
        end else if (t <= D + 2 * N * D) begin
          u = t - D - 1;
          k = u / (2 * D);
          e_ssel = 1'b0; e_busy = 1'b1;
          if ((u % (2 * D)) < D) begin
            e_sck = 1'b1; e_mosi = tx_cap[N-1-k];
          end else if (k < N - 1) begin
            e_mosi = tx_cap[N-2-k];
          end else begin
            mosi_known = 1'b0;
          end
        end else if (t <= D * (2 * N + 2)) begin
          e_busy = 1'b1;
        end else begin
          e_done = 1'b1; rx_model = rx_next; active = 1'b0;
        end
      end
      if (armed) begin
        check($sformatf("i%0d_pins(sck,ssel,busy,done,mosi)", gi),
              {59'd0, bus.sck, bus.ssel, bus.busy, bus.done, mosi_known ? bus.mosi : 1'b0},
              {59'd0, e_sck, e_ssel, e_busy, e_done, e_mosi & mosi_known});
        check($sformatf("i%0d_rx_data", gi), 64'(bus.rx_data), 64'(rx_model));
      end
      if (bus.done === 1'b1) begin
        done_count[gi]++;
        done_rel[gi] = cyc - start_cyc[gi];
      end
      if (bus.sck === 1'b1 && obs_sck === 1'b0) begin
        rise_cnt[gi]++;
        mosi_seq[gi] = {mosi_seq[gi][30:0], bus.mosi};
      end
      if (bus.ssel === 1'b1) begin
        ssel_run++;
      end else begin
        if (ssel_run > 0) last_gap[gi] = ssel_run;
        ssel_run = 0;
      end
      obs_sck = bus.sck;
      if (rst_v[gi] === 1'b1) begin
        armed = 1'b1; active = 1'b0; rx_model = '0;
      end else if (armed && start_v[gi] === 1'b1 && !e_busy) begin
        active  = 1'b1;
        t0      = cyc;
        tx_cap  = tx_v[gi][N-1:0];
        rx_next = loop_v[gi] ? tx_v[gi][N-1:0] : slave_word[gi][N-1:0];
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(int i, logic [31:0] tx);
    tx_v[i] = tx; start_v[i] = 1'b1; start_cyc[i] = cyc;
    tick(1);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_done(int i, int budget);
    int base = done_count[i];
    int n = 0;
    while (done_count[i] == base && n < budget) begin
      tick(1);
      n++;
    end
    check($sformatf("i%0d_done_seen", i), 64'(done_count[i] - base), 64'd1);
  endtask

  initial begin
    int base;
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b1; start_v[i] = 1'b0; tx_v[i] = '0; loop_v[i] = 1'b0;
      slave_word[i] = '0; start_cyc[i] = 0; done_count[i] = 0; done_rel[i] = 0;
      rise_cnt[i] = 0; mosi_seq[i] = '0; last_gap[i] = 0;
    end
    tick(3);
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    tick(2);
    check("reset_ssel", 64'(g[0].bus.ssel), 64'd1);
    check("reset_busy", 64'(g[0].bus.busy), 64'd0);
    check("reset_rx", 64'(g[0].bus.rx_data), 64'd0);
    check("reset_mosi", 64'(g[1].bus.mosi), 64'd0);

    // Command readback against a slave returning 0x12345678.
    slave_word[0] = 32'h12345678; rise_cnt[0] = 0;
    pulse_start(0, 32'hCC000000);
    wait_done(0, 400);
    check("cmd_done_cycle", 64'(done_rel[0]), 64'd265);
    check("cmd_rx", 64'(g[0].bus.rx_data), 64'h12345678);
    check("cmd_sck_rises", 64'(rise_cnt[0]), 64'd32);

    // Loopback: mosi sampled at each rising sck must rebuild tx.
    loop_v[0] = 1'b1; mosi_seq[0] = '0;
    pulse_start(0, 32'hA5A5F00F);
    wait_done(0, 400);
    check("loop_rx", 64'(g[0].bus.rx_data), 64'hA5A5F00F);
    check("loop_mosi_seq", 64'(mosi_seq[0]), 64'hA5A5F00F);
    loop_v[0] = 1'b0;
    tick(2);

    // Busy rejection: a start 50 cycles in is dropped.
    slave_word[0] = 32'h0F1E2D3C;
    base = done_count[0];
    pulse_start(0, 32'h3C3C3C3C);
    tick(49);
    tx_v[0] = 32'hFFFFFFFF; start_v[0] = 1'b1;
    tick(1);
    start_v[0] = 1'b0;
    wait_done(0, 400);
    tick(20);
    check("reject_done_count", 64'(done_count[0] - base), 64'd1);
    check("reject_rx", 64'(g[0].bus.rx_data), 64'h0F1E2D3C);
    check("reject_idle", 64'(g[0].bus.busy), 64'd0);

    // Reset during bit 10 (its high phase spans frame cycles 85..88).
    slave_word[0] = $urandom;
    base = done_count[0];
    pulse_start(0, $urandom);
    tick(87);
    rst_v[0] = 1'b1;
    tick(1);
    rst_v[0] = 1'b0;
    check("abort_ssel", 64'(g[0].bus.ssel), 64'd1);
    check("abort_sck", 64'(g[0].bus.sck), 64'd0);
    check("abort_mosi", 64'(g[0].bus.mosi), 64'd0);
    check("abort_busy", 64'(g[0].bus.busy), 64'd0);
    check("abort_rx", 64'(g[0].bus.rx_data), 64'd0);
    tick(300);
    check("abort_no_done", 64'(done_count[0] - base), 64'd0);

    // Reset wins over a coincident start.
    rst_v[1] = 1'b1; tx_v[1] = 32'hFF; start_v[1] = 1'b1;
    tick(1);
    rst_v[1] = 1'b0; start_v[1] = 1'b0;
    check("rst_over_start_busy", 64'(g[1].bus.busy), 64'd0);
    tick(3);

    // Minimum divider, 8-bit frame.
    slave_word[1] = 32'h5A; rise_cnt[1] = 0; mosi_seq[1] = '0;
    pulse_start(1, 32'h81);
    wait_done(1, 200);
    check("min_done_cycle", 64'(done_rel[1]), 64'd37);
    check("min_mosi_seq", 64'(mosi_seq[1][7:0]), 64'h81);
    check("min_rx", 64'(g[1].bus.rx_data), 64'h5A);
    check("min_sck_rises", 64'(rise_cnt[1]), 64'd8);

    // Back-to-back: restart on the done cycle; ssel is high for the 2 GAP cycles plus the idle done cycle.
    slave_word[1] = 32'h3C;
    pulse_start(1, 32'h96);
    tick(36);
    slave_word[1] = 32'hC3;
    pulse_start(1, 32'h69);
    wait_done(1, 200);
    check("b2b_done_cycle", 64'(done_rel[1]), 64'd37);
    check("b2b_ssel_gap", 64'(last_gap[1]), 64'd3);
    check("b2b_rx", 64'(g[1].bus.rx_data), 64'hC3);

    // Randomized frames with ignored starts while busy.
    for (int r = 0; r < 10; r++) begin
      int i;
      i = int'($urandom_range(0, 1));
      slave_word[i] = $urandom;
      loop_v[i] = 1'($urandom_range(0, 1));
      pulse_start(i, $urandom);
      for (int p = 0; p < 3; p++) begin
        tick(int'($urandom_range(1, 8)));
        tx_v[i] = $urandom; start_v[i] = 1'b1;
        tick(1);
        start_v[i] = 1'b0;
      end
      wait_done(i, 400);
      tick(int'($urandom_range(1, 3)));
      loop_v[i] = 1'b0;
    end

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
